// File: rtl/membus_arb_pkg.sv
// Shared types and default widths for the membus 2:1 arbiter.
package membus_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef logic owner_t;

endpackage

// File: rtl/membus_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that was not granted last.
module membus_arb_rr
    import membus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     sel,
    output logic       any
);

    // Pick the winner; with no requests sel defaults to requester 0.
    always_comb begin
        any = |req;
        sel = 1'b0;
        if (req == 2'b11) begin
            sel = !last_owner;
        end else if (req[1]) begin
            sel = 1'b1;
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// 2:1 arbiter in front of the core membus port: round-robin grant of one
// transaction at a time, response routed back to its owner, sticky
// response-timeout flag.
module membus_arbiter
    import membus_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 1024
)(
    input  logic                  ACLK,
    input  logic                  ARESETN,

    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_W-1:0]     s0_addr,
    input  logic                  s0_wen,
    input  logic [DATA_W-1:0]     s0_wdata,
    input  logic [DATA_W/8-1:0]   s0_wmask,
    output logic                  s0_rvalid,
    output logic [DATA_W-1:0]     s0_rdata,

    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_W-1:0]     s1_addr,
    input  logic                  s1_wen,
    input  logic [DATA_W-1:0]     s1_wdata,
    input  logic [DATA_W/8-1:0]   s1_wmask,
    output logic                  s1_rvalid,
    output logic [DATA_W-1:0]     s1_rdata,

    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  m_wen,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wmask,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,

    output logic                  busy,
    output logic                  owner,
    output logic                  err_timeout
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t             r_state;
    state_t             w_state_next;
    owner_t             r_owner;
    owner_t             r_last_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_err;
    owner_t             w_sel;
    logic               w_any;
    logic               w_accept;
    logic [MASK_W-1:0]  w_wmask;

    membus_arb_rr u_rr (
        .req        ({s1_valid, s0_valid}),
        .last_owner (r_last_owner),
        .sel        (w_sel),
        .any        (w_any)
    );

    // Payload is a straight mux from the selected requester.
    assign m_addr   = w_sel ? s1_addr  : s0_addr;
    assign m_wen    = w_sel ? s1_wen   : s0_wen;
    assign m_wdata  = w_sel ? s1_wdata : s0_wdata;
    assign w_wmask  = w_sel ? s1_wmask : s0_wmask;
    assign m_wmask  = w_wmask;

    // Response data fans out to both; only the rvalid strobes are steered.
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;

    assign owner       = r_owner;
    assign err_timeout = r_err;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus handshake/response steering; all strobes forced low in reset.
    always_comb begin
        w_state_next = r_state;
        m_valid      = 1'b0;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                m_valid  = w_any;
                s0_ready = !w_sel && m_ready;
                s1_ready = w_sel && m_ready;
                w_accept = w_any && m_ready;
                if (w_accept) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                busy      = 1'b1;
                s0_rvalid = m_rvalid && !r_owner;
                s1_rvalid = m_rvalid && r_owner;
                if (m_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (!ARESETN) begin
            m_valid   = 1'b0;
            s0_ready  = 1'b0;
            s1_ready  = 1'b0;
            s0_rvalid = 1'b0;
            s1_rvalid = 1'b0;
            busy      = 1'b0;
            w_accept  = 1'b0;
        end
    end

    // Grant bookkeeping and the saturating WAIT-cycle counter behind the timeout flag.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_sel;
                r_last_owner <= w_sel;
                r_cnt        <= '0;
            end else if ((r_state == WAIT) && (r_cnt != CNT_MAX)) begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule
